// File: rtl/streamline_ctrl.sv
// streamline_ctrl
//   Two-stage pipeline scheduler for layer1 -> ping-pong temp buffer -> layer2.
//   Layer1 fills one bank while layer2 drains the other. The block issues
//   start/clear pulses to both layers, tracks bank ownership and occupancy,
//   counts completed frames and pulses done_o at the end of a batch.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               batch start pulse (accepted only when idle)
//   num_frames_i [FW]     frames in the batch, sampled with start_i
//   l1_start_o/clear_o    one-cycle start + accumulator clear to layer1
//   l1_bank_o             bank layer1 writes (valid start .. done)
//   l1_done_i             layer1 frame-complete pulse
//   l2_start_o/clear_o    one-cycle start + accumulator clear to layer2
//   l2_bank_o             bank layer2 reads (valid start .. done)
//   l2_done_i             layer2 frame-complete pulse
//   busy_o                batch running
//   frame_cnt_o [FW]      frames completed by layer2 in this batch
//   done_o                one-cycle batch-complete pulse
module streamline_ctrl #(
  parameter int FW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [FW-1:0] num_frames_i,
  output logic          l1_start_o,
  output logic          l1_clear_o,
  output logic          l1_bank_o,
  input  logic          l1_done_i,
  output logic          l2_start_o,
  output logic          l2_clear_o,
  output logic          l2_bank_o,
  input  logic          l2_done_i,
  output logic          busy_o,
  output logic [FW-1:0] frame_cnt_o,
  output logic          done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]    r_state;
  logic [FW-1:0] r_n;
  logic [FW-1:0] r_issued;
  logic [FW-1:0] r_frame_cnt;
  logic [1:0]    r_full;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic          r_l1_busy;
  logic          r_l2_busy;
  logic          r_l1_bank;
  logic          r_l2_bank;

  logic          w_run;
  logic          w_l1_issue;
  logic          w_l2_issue;
  logic          w_l1_fin;
  logic          w_l2_fin;
  logic [FW-1:0] w_cnt_inc;
  logic [1:0]    w_full_nxt;

  assign w_run = (r_state == S_RUN);

  // Issue decisions are decoded purely from registered state, so a done
  // input sampled at one edge becomes visible in the following cycle's
  // start pulses and the outputs never depend combinationally on inputs.
  assign w_l1_issue = w_run && !r_l1_busy && (r_issued < r_n) && !r_full[r_wr_ptr];
  assign w_l2_issue = w_run && !r_l2_busy && r_full[r_rd_ptr];

  // Done inputs count only while the matching layer is actually running.
  assign w_l1_fin  = l1_done_i && r_l1_busy;
  assign w_l2_fin  = l2_done_i && r_l2_busy;
  assign w_cnt_inc = r_frame_cnt + 1'b1;

  // The two layers always own different banks, so both updates may apply
  // in the same cycle without conflict.
  always_comb begin
    w_full_nxt = r_full;
    if (w_l1_fin) w_full_nxt[r_l1_bank] = 1'b1;
    if (w_l2_fin) w_full_nxt[r_l2_bank] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_issued    <= '0;
      r_frame_cnt <= '0;
      r_full      <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_l1_busy   <= 1'b0;
      r_l2_busy   <= 1'b0;
      r_l1_bank   <= 1'b0;
      r_l2_bank   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_n         <= num_frames_i;
            r_issued    <= '0;
            r_frame_cnt <= '0;
            r_full      <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_l1_busy   <= 1'b0;
            r_l2_busy   <= 1'b0;
            r_l1_bank   <= 1'b0;
            r_l2_bank   <= 1'b0;
            r_state     <= (num_frames_i == '0) ? S_FIN : S_RUN;
          end
        end

        S_RUN: begin
          // Issue and finish are mutually exclusive per layer: issue needs
          // busy low, finish needs busy high.
          if (w_l1_issue) begin
            r_l1_bank <= r_wr_ptr;
            r_wr_ptr  <= ~r_wr_ptr;
            r_issued  <= r_issued + 1'b1;
            r_l1_busy <= 1'b1;
          end else if (w_l1_fin) begin
            r_l1_busy <= 1'b0;
          end

          if (w_l2_issue) begin
            r_l2_bank <= r_rd_ptr;
            r_rd_ptr  <= ~r_rd_ptr;
            r_l2_busy <= 1'b1;
          end else if (w_l2_fin) begin
            r_l2_busy   <= 1'b0;
            r_frame_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_n) r_state <= S_FIN;
          end

          r_full <= w_full_nxt;
        end

        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // While a start is issued the bank comes straight from the write/read
  // pointer; afterwards the latched copy holds it until the layer's done.
  assign l1_start_o  = w_l1_issue;
  assign l1_clear_o  = w_l1_issue;
  assign l1_bank_o   = w_l1_issue ? r_wr_ptr : r_l1_bank;
  assign l2_start_o  = w_l2_issue;
  assign l2_clear_o  = w_l2_issue;
  assign l2_bank_o   = w_l2_issue ? r_rd_ptr : r_l2_bank;
  assign busy_o      = w_run;
  assign done_o      = (r_state == S_FIN);
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_streamline_ctrl.sv
// Directed testbench for streamline_ctrl. Cycle numbers in expectations are
// relative to the cycle in which start_i is high (cycle 0).
module tb_streamline_ctrl;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [FW-1:0] num_frames_i;
  logic          l1_start_o, l1_clear_o, l1_bank_o, l1_done_i;
  logic          l2_start_o, l2_clear_o, l2_bank_o, l2_done_i;
  logic          busy_o, done_o;
  logic [FW-1:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  // Event logs filled by the responder.
  int l1_t[$], l1_b[$], l2_t[$], l2_b[$];
  int done_t[$], done_fc[$], done_busy[$];
  bit busy_seen;
  int clr_mis;

  // Automatic layer model: done returns lat cycles after each start.
  bit auto_en = 1'b0;
  int lat1 = 1, lat2 = 1;
  int due1 = -1000, due2 = -1000;

  streamline_ctrl #(.FW(FW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .num_frames_i(num_frames_i),
    .l1_start_o  (l1_start_o),
    .l1_clear_o  (l1_clear_o),
    .l1_bank_o   (l1_bank_o),
    .l1_done_i   (l1_done_i),
    .l2_start_o  (l2_start_o),
    .l2_clear_o  (l2_clear_o),
    .l2_bank_o   (l2_bank_o),
    .l2_done_i   (l2_done_i),
    .busy_o      (busy_o),
    .frame_cnt_o (frame_cnt_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic responder();
    forever begin
      @(negedge clk);
      if (l1_start_o) begin l1_t.push_back(cyc - t0); l1_b.push_back(int'(l1_bank_o)); end
      if (l2_start_o) begin l2_t.push_back(cyc - t0); l2_b.push_back(int'(l2_bank_o)); end
      if (done_o) begin
        done_t.push_back(cyc - t0);
        done_fc.push_back(int'(frame_cnt_o));
        done_busy.push_back(int'(busy_o));
      end
      if (busy_o) busy_seen = 1'b1;
      if (l1_clear_o !== l1_start_o || l2_clear_o !== l2_start_o) clr_mis++;
      if (auto_en) begin
        l1_done_i = (cyc == due1);
        l2_done_i = (cyc == due2);
      end
      if (l1_start_o) due1 = cyc + lat1;
      if (l2_start_o) due2 = cyc + lat2;
    end
  endtask

  // Called only while the DUT is idle, so no log entry can race the clear.
  task automatic clear_logs();
    l1_t.delete(); l1_b.delete(); l2_t.delete(); l2_b.delete();
    done_t.delete(); done_fc.delete(); done_busy.delete();
    busy_seen = 1'b0;
    clr_mis   = 0;
  endtask

  // Assumes the caller is at a negedge; returns at the negedge of cycle 1.
  task automatic start_batch(input int n);
    t0           = cyc;
    start_i      = 1'b1;
    num_frames_i = FW'(n);
    tick();
    start_i      = 1'b0;
    num_frames_i = 8'hA5;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; num_frames_i = '0;
    l1_done_i = 1'b0; l2_done_i = 1'b0;
    tick(3);
    checks++;
    if ({l1_start_o, l1_clear_o, l1_bank_o, l2_start_o, l2_clear_o, l2_bank_o,
         busy_o, done_o, frame_cnt_o} !== '0)
      begin errors++; $display("FAIL reset_outputs got %b exp 0", {l1_start_o, l1_clear_o,
        l1_bank_o, l2_start_o, l2_clear_o, l2_bank_o, busy_o, done_o, frame_cnt_o}); end
    rst_i = 1'b0;
    tick(2);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || l1_start_o !== 1'b0)
      begin errors++; $display("FAIL idle_quiet busy %b done %b l1s %b exp 0", busy_o, done_o, l1_start_o); end
  endtask

  // N=1 with 5-cycle latencies, then N=0 started in the first idle cycle.
  task automatic test_single_and_zero();
    lat1 = 5; lat2 = 5; auto_en = 1'b1;
    clear_logs();
    start_batch(1);
    tick(13);   // relative cycle 14: first IDLE cycle after done
    checks++;
    if (l1_t.size() != 1 || l1_t[0] != 1 || l1_b[0] != 0)
      begin errors++; $display("FAIL single_l1 got n=%0d t=%0d exp n=1 t=1 bank 0", l1_t.size(), (l1_t.size() > 0) ? l1_t[0] : -1); end
    checks++;
    if (l2_t.size() != 1 || l2_t[0] != 7 || l2_b[0] != 0)
      begin errors++; $display("FAIL single_l2 got n=%0d t=%0d exp n=1 t=7 bank 0", l2_t.size(), (l2_t.size() > 0) ? l2_t[0] : -1); end
    checks++;
    if (done_t.size() != 1 || done_t[0] != 13 || done_fc[0] != 1 || done_busy[0] != 0)
      begin errors++; $display("FAIL single_done got n=%0d t=%0d exp n=1 t=13 cnt 1 busy 0", done_t.size(), (done_t.size() > 0) ? done_t[0] : -1); end

    clear_logs();
    start_batch(0);
    tick(4);
    checks++;
    if (done_t.size() != 1 || done_t[0] != 1)
      begin errors++; $display("FAIL zero_done got n=%0d t=%0d exp n=1 t=1", done_t.size(), (done_t.size() > 0) ? done_t[0] : -1); end
    checks++;
    if (l1_t.size() != 0 || l2_t.size() != 0 || busy_seen)
      begin errors++; $display("FAIL zero_quiet got l1=%0d l2=%0d busy=%0d exp 0 0 0", l1_t.size(), l2_t.size(), busy_seen); end
    checks++;
    if (done_fc[0] != 0)
      begin errors++; $display("FAIL zero_cnt got %0d exp 0", done_fc[0]); end
  endtask

  // N=3, latencies 4/4: both layers overlap, banks alternate.
  task automatic test_pipeline();
    int e_t1[3] = '{1, 6, 11};
    int e_t2[3] = '{6, 11, 16};
    int e_b[3]  = '{0, 1, 0};
    lat1 = 4; lat2 = 4;
    clear_logs();
    tick();
    start_batch(3);
    tick(22);
    checks++;
    if (l1_t.size() != 3 || l2_t.size() != 3)
      begin errors++; $display("FAIL pipe_count got l1=%0d l2=%0d exp 3 3", l1_t.size(), l2_t.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (l1_t[i] != e_t1[i] || l1_b[i] != e_b[i])
          begin errors++; $display("FAIL pipe_l1[%0d] got t=%0d b=%0d exp t=%0d b=%0d", i, l1_t[i], l1_b[i], e_t1[i], e_b[i]); end
        checks++;
        if (l2_t[i] != e_t2[i] || l2_b[i] != e_b[i])
          begin errors++; $display("FAIL pipe_l2[%0d] got t=%0d b=%0d exp t=%0d b=%0d", i, l2_t[i], l2_b[i], e_t2[i], e_b[i]); end
      end
    end
    checks++;
    if (done_t.size() != 1 || done_t[0] != 21 || done_fc[0] != 3)
      begin errors++; $display("FAIL pipe_done got n=%0d t=%0d exp n=1 t=21 cnt 3", done_t.size(), (done_t.size() > 0) ? done_t[0] : -1); end
    checks++;
    if (frame_cnt_o !== 8'd3 || clr_mis != 0)
      begin errors++; $display("FAIL pipe_cnt_clear got cnt=%0d clrmis=%0d exp 3 0", frame_cnt_o, clr_mis); end
  endtask

  // N=4, layer1 fast (2), layer2 slow (10): both banks fill, layer1 stalls
  // and restarts the cycle after each layer2 done.
  task automatic test_backpressure();
    int e_t1[4] = '{1, 4, 15, 26};
    int e_t2[4] = '{4, 15, 26, 37};
    int e_b[4]  = '{0, 1, 0, 1};
    lat1 = 2; lat2 = 10;
    clear_logs();
    tick();
    start_batch(4);
    tick(50);
    checks++;
    if (l1_t.size() != 4 || l2_t.size() != 4)
      begin errors++; $display("FAIL bp_count got l1=%0d l2=%0d exp 4 4", l1_t.size(), l2_t.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (l1_t[i] != e_t1[i] || l1_b[i] != e_b[i])
          begin errors++; $display("FAIL bp_l1[%0d] got t=%0d b=%0d exp t=%0d b=%0d", i, l1_t[i], l1_b[i], e_t1[i], e_b[i]); end
        checks++;
        if (l2_t[i] != e_t2[i] || l2_b[i] != e_b[i])
          begin errors++; $display("FAIL bp_l2[%0d] got t=%0d b=%0d exp t=%0d b=%0d", i, l2_t[i], l2_b[i], e_t2[i], e_b[i]); end
      end
    end
    checks++;
    if (done_t.size() != 1 || done_t[0] != 48 || done_fc[0] != 4)
      begin errors++; $display("FAIL bp_done got n=%0d t=%0d exp n=1 t=48 cnt 4", done_t.size(), (done_t.size() > 0) ? done_t[0] : -1); end
  endtask

  // Hand-driven dones: ignored start during RUN, spurious l2 done,
  // simultaneous l1/l2 done.
  task automatic test_batch_behaviour();
    auto_en = 1'b0;
    l1_done_i = 1'b0; l2_done_i = 1'b0;
    clear_logs();
    tick();
    start_batch(2);                                   // at rel 1
    tick();                                           // rel 2
    start_i = 1'b1; num_frames_i = 8'd7; l2_done_i = 1'b1;
    tick();                                           // rel 3
    start_i = 1'b0; l2_done_i = 1'b0;
    checks++;
    if (frame_cnt_o !== 8'd0 || busy_o !== 1'b1)
      begin errors++; $display("FAIL spurious_ignored got cnt=%0d busy=%b exp 0 1", frame_cnt_o, busy_o); end
    l1_done_i = 1'b1;
    tick();                                           // rel 4
    l1_done_i = 1'b0;
    checks++;
    if ({l1_start_o, l1_bank_o, l2_start_o, l2_bank_o} !== 4'b1110)
      begin errors++; $display("FAIL overlap_start got %b exp 1110", {l1_start_o, l1_bank_o, l2_start_o, l2_bank_o}); end
    tick(2);                                          // rel 6
    l1_done_i = 1'b1; l2_done_i = 1'b1;
    tick();                                           // rel 7
    l1_done_i = 1'b0; l2_done_i = 1'b0;
    checks++;
    if ({l1_start_o, l2_start_o, l2_bank_o} !== 3'b011 || frame_cnt_o !== 8'd1)
      begin errors++; $display("FAIL simul_done got starts=%b cnt=%0d exp 011 1", {l1_start_o, l2_start_o, l2_bank_o}, frame_cnt_o); end
    tick(2);                                          // rel 9
    l2_done_i = 1'b1;
    tick();                                           // rel 10
    l2_done_i = 1'b0;
    checks++;
    if (done_o !== 1'b1 || frame_cnt_o !== 8'd2 || busy_o !== 1'b0)
      begin errors++; $display("FAIL manual_done got done=%b cnt=%0d busy=%b exp 1 2 0", done_o, frame_cnt_o, busy_o); end
    tick(3);
    checks++;
    if (l1_t.size() != 2 || done_t.size() != 1)
      begin errors++; $display("FAIL manual_totals got l1=%0d done=%0d exp 2 1", l1_t.size(), done_t.size()); end
  endtask

  // Reset after two frames of an N=5 batch, then a clean N=2 batch.
  task automatic test_reset_mid();
    lat1 = 4; lat2 = 4; auto_en = 1'b1;
    clear_logs();
    tick();
    start_batch(5);
    tick(15);                                         // rel 16
    checks++;
    if (frame_cnt_o !== 8'd2)
      begin errors++; $display("FAIL mid_progress got cnt=%0d exp 2", frame_cnt_o); end
    rst_i = 1'b1; auto_en = 1'b0;
    tick();                                           // rel 17
    l1_done_i = 1'b0; l2_done_i = 1'b0;
    checks++;
    if ({l1_start_o, l1_clear_o, l1_bank_o, l2_start_o, l2_clear_o, l2_bank_o,
         busy_o, done_o, frame_cnt_o} !== '0)
      begin errors++; $display("FAIL mid_reset_outputs got %b exp 0", {l1_start_o, l1_clear_o,
        l1_bank_o, l2_start_o, l2_clear_o, l2_bank_o, busy_o, done_o, frame_cnt_o}); end
    rst_i = 1'b0;
    tick(8);                                          // rel 25, past stale dues
    checks++;
    if (done_t.size() != 0 || busy_o !== 1'b0)
      begin errors++; $display("FAIL mid_no_done got done=%0d busy=%b exp 0 0", done_t.size(), busy_o); end

    clear_logs();
    auto_en = 1'b1;
    start_batch(2);
    tick(17);
    checks++;
    if (l1_t.size() != 2 || l1_t[0] != 1 || l1_b[0] != 0 || l1_t[1] != 6 || l1_b[1] != 1)
      begin errors++; $display("FAIL post_l1 got n=%0d t0=%0d b0=%0d exp n=2 t0=1 b0=0", l1_t.size(), (l1_t.size() > 0) ? l1_t[0] : -1, (l1_b.size() > 0) ? l1_b[0] : -1); end
    checks++;
    if (l2_t.size() != 2 || l2_t[0] != 6 || l2_b[0] != 0 || l2_t[1] != 11 || l2_b[1] != 1)
      begin errors++; $display("FAIL post_l2 got n=%0d t0=%0d b0=%0d exp n=2 t0=6 b0=0", l2_t.size(), (l2_t.size() > 0) ? l2_t[0] : -1, (l2_b.size() > 0) ? l2_b[0] : -1); end
    checks++;
    if (done_t.size() != 1 || done_t[0] != 16 || done_fc[0] != 2)
      begin errors++; $display("FAIL post_done got n=%0d t=%0d exp n=1 t=16 cnt 2", done_t.size(), (done_t.size() > 0) ? done_t[0] : -1); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    fork
      responder();
    join_none
    test_reset();
    test_single_and_zero();
    test_pipeline();
    test_backpressure();
    test_batch_behaviour();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
